// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared constants, state encoding and helpers for the
//                boot loader. BOOT_BASE_ADDR is also the core reset vector.
//  Options     : BOOT_CHECKSUM_EN (see boot_loader.sv)
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Start-of-frame marker
  localparam logic [7:0]  BOOT_MAGIC     = 8'hB5;

  // Byte address of payload word 0, shared with the core reset vector
  localparam logic [63:0] BOOT_BASE_ADDR = 64'h8000_0000;

  // Loader states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } boot_state_e;

  // The byte stream is accepted in every state except WRITE and DONE
  function automatic logic rx_open(boot_state_e s);
    return (s != WRITE) && (s != DONE);
  endfunction

endpackage : boot_pkg
`default_nettype wire

// File: rtl/boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader_if
//  Description : Byte-stream input, memory write port and core control
//                outputs of the boot loader. The loader uses the master
//                modport; the environment (UART, memory, core) the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface boot_loader_if #(
  parameter int XLEN = 64
) ();

  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [63:0]     mem_wdata;
  logic            mem_ready;
  logic            core_resetn;
  logic            boot_done;
  logic            boot_error;

  modport master (
    input  rx_data, rx_valid, mem_ready,
    output rx_ready, mem_we, mem_addr, mem_wdata,
           core_resetn, boot_done, boot_error
  );

  modport slave (
    output rx_data, rx_valid, mem_ready,
    input  rx_ready, mem_we, mem_addr, mem_wdata,
           core_resetn, boot_done, boot_error
  );

endinterface : boot_loader_if
`default_nettype wire

// File: rtl/boot_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : boot_word_packer
//  Description : Assembles eight bytes into a little-endian 64-bit word.
//                Byte k of a word lands in bits [8k+7:8k]. o_word_full
//                flags the strobe that delivers the eighth byte, so the
//                caller can leave its byte state on that same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_word_packer (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [7:0]  i_byte,
  input  wire logic        i_strobe,
  input  wire logic        i_clear,
  output logic      [63:0] o_word,
  output logic             o_word_full
);

  logic [2:0]  r_cnt;
  logic [63:0] r_word;

  // Deposit each strobed byte at the lane selected by the byte counter
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt  <= 3'd0;
      r_word <= 64'd0;
    end else if (i_strobe) begin
      r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
      r_cnt                        <= r_cnt + 3'd1;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = i_strobe && !i_clear && (r_cnt == 3'd7);

endmodule : boot_word_packer
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader
//  Description : Receives a framed byte stream (magic, 16-bit LE word count,
//                payload words, optional checksum), writes the words to main
//                memory from BASE_ADDR upward while holding the core in
//                reset, then releases core reset after a good frame.
//  Options     : BOOT_CHECKSUM_EN - when defined the frame ends with an
//                8-bit modular sum of the payload bytes, checked in CSUM.
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
  import boot_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(BOOT_BASE_ADDR),
  parameter int              MAX_WORDS = 4096
) (
  input wire logic     clk,
  input wire logic     reset,
  boot_loader_if.master bus
);

  // Index wide enough to hold MAX_WORDS itself, so it never wraps
  localparam int IDXW = $clog2(MAX_WORDS + 1);

  boot_state_e     r_state;
  boot_state_e     w_next;
  logic            r_rx_ready;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic            r_core_resetn;
  logic            r_boot_done;
  logic            r_boot_error;
  logic [7:0]      r_len0;
  logic [15:0]     r_count;
  logic [IDXW-1:0] r_idx;

  logic            w_hs;
  logic            w_wr;
  logic [15:0]     w_len;
  logic            w_len_bad;
  logic            w_last;
  logic [XLEN-1:0] w_addr;
  logic            w_pack_strobe;
  logic            w_pack_clear;
  logic            w_word_full;
  logic [63:0]     w_word;

  assign w_hs      = bus.rx_valid && r_rx_ready;
  assign w_wr      = r_mem_we && bus.mem_ready;
  assign w_len     = {bus.rx_data, r_len0};
  assign w_len_bad = (w_len == 16'd0) || (int'({16'd0, w_len}) > MAX_WORDS);
  assign w_last    = (17'(r_idx) + 17'd1) == {1'b0, r_count};
  assign w_addr    = BASE_ADDR + (XLEN'(r_idx) << 3);

  // Packer is cleared when a new payload starts, fed only in DATA
  assign w_pack_strobe = w_hs && (r_state == DATA);
  assign w_pack_clear  = w_hs && (r_state == LEN1);

  boot_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_byte      (bus.rx_data),
    .i_strobe    (w_pack_strobe),
    .i_clear     (w_pack_clear),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running modular sum of payload bytes only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum <= 8'd0;
    end else if (w_pack_clear) begin
      r_csum <= 8'd0;
    end else if (w_pack_strobe) begin
      r_csum <= r_csum + bus.rx_data;
    end
  end
`endif

  // Next-state decode; outputs are registered from this in the FSM flop
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_hs && bus.rx_data == BOOT_MAGIC) w_next = LEN0;
      LEN0:  if (w_hs) w_next = LEN1;
      LEN1:  if (w_hs) w_next = w_len_bad ? ERROR : DATA;
      DATA:  if (w_word_full) w_next = WRITE;
      WRITE: begin
        if (w_wr) begin
`ifdef BOOT_CHECKSUM_EN
          w_next = w_last ? CSUM : DATA;
`else
          w_next = w_last ? DONE : DATA;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM:  if (w_hs) w_next = (bus.rx_data == r_csum) ? DONE : ERROR;
`endif
      DONE:  w_next = DONE;
      ERROR: if (w_hs && bus.rx_data == BOOT_MAGIC) w_next = LEN0;
      default: w_next = IDLE;
    endcase
  end

  // Loader FSM: state, frame bookkeeping and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rx_ready    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_core_resetn <= 1'b0;
      r_boot_done   <= 1'b0;
      r_boot_error  <= 1'b0;
      r_len0        <= 8'd0;
      r_count       <= 16'd0;
      r_idx         <= '0;
    end else begin
      r_state       <= w_next;
      r_rx_ready    <= rx_open(w_next);
      r_mem_we      <= (w_next == WRITE);
      r_core_resetn <= (w_next == DONE);
      r_boot_done   <= (w_next == DONE);
      r_boot_error  <= (w_next == ERROR);

      if (w_hs && r_state == LEN0) r_len0 <= bus.rx_data;

      if (w_pack_clear) begin
        r_count <= w_len;
        r_idx   <= '0;
      end else if (r_state == WRITE && w_wr) begin
        r_idx   <= r_idx + IDXW'(1);
      end

      // Address is latched on WRITE entry and held through backpressure
      if (w_next == WRITE && r_state != WRITE) r_mem_addr <= w_addr;
    end
  end

  assign bus.rx_ready    = r_rx_ready;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = w_word;
  assign bus.core_resetn = r_core_resetn;
  assign bus.boot_done   = r_boot_done;
  assign bus.boot_error  = r_boot_error;

endmodule : boot_loader
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader
//  Description : Self-checking bench for boot_loader. Expected memory writes
//                are queued as payload is driven and compared when the DUT
//                completes each write. Frame outcomes come from a vector
//                table; reset, error recovery and checksum corners are
//                hand-written sequences. Honours BOOT_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;
  import boot_pkg::*;

  localparam logic [63:0] W0 = 64'h00A00093_00000013;
  localparam logic [63:0] W1 = 64'h002081B3_01400113;
  localparam logic [63:0] W2 = 64'h00000013_00100073;
  localparam logic [63:0] NO_STALL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [15:0] count;
    int          nwords;
    logic [63:0] w[3];
    logic        garbage;
    logic [63:0] stall_at;
    logic        exp_done;
  } vec_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];

  logic [63:0] stall_addr = NO_STALL;
  int          stall_cnt  = 0;
  logic [63:0] hold_addr;
  logic [63:0] hold_data;

  boot_loader_if #(.XLEN(64)) bus ();

  boot_loader #(
    .XLEN      (64),
    .BASE_ADDR (64'h8000_0000),
    .MAX_WORDS (4096)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Memory model: decides mem_ready on the falling edge and scores writes
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_addr == stall_addr && stall_cnt < 5) begin
      if (stall_cnt == 0) begin
        hold_addr = bus.mem_addr;
        hold_data = bus.mem_wdata;
      end else begin
        check("stall_addr_stable", bus.mem_addr, hold_addr);
        check("stall_data_stable", bus.mem_wdata, hold_data);
      end
      check("stall_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
      bus.mem_ready = 1'b0;
      stall_cnt++;
    end else begin
      bus.mem_ready = 1'b1;
    end
    if (bus.mem_we && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", bus.mem_addr, 64'd0 - 64'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int  n  = 0;
    logic ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.rx_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout actual=%h required=accepted", b);
    end
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    stall_cnt = 0;
  endtask

  task automatic send_frame(input logic [15:0] count, input int nwords,
                            input logic [63:0] w[3], input logic garbage,
                            input logic bad_csum);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    if (garbage) begin
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h42);
    end
    send_byte(BOOT_MAGIC);
    send_byte(count[7:0]);
    send_byte(count[15:8]);
    for (int i = 0; i < nwords; i++) begin
      wr_t e;
      e.addr = 64'h8000_0000 + 64'(i) * 64'd8;
      e.data = w[i];
      exp_q.push_back(e);
      for (int k = 0; k < 8; k++) begin
        b = w[i][8*k +: 8];
        sum = sum + b;
        send_byte(b);
      end
      @(negedge clk);
      check("we_after_8th_byte", {63'd0, bus.mem_we}, 64'd1);
      @(posedge clk);
      #1;
    end
`ifdef BOOT_CHECKSUM_EN
    if (nwords > 0) send_byte(sum + {7'd0, bad_csum});
`else
    if (bad_csum) sum = sum + 8'd1;
`endif
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string nm, input logic exp_done);
    int n = 0;
    while (!(bus.boot_done || bus.boot_error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({nm, "_done"},   {63'd0, bus.boot_done},   {63'd0, exp_done});
    check({nm, "_error"},  {63'd0, bus.boot_error},  {63'd0, !exp_done});
    check({nm, "_resetn"}, {63'd0, bus.core_resetn}, {63'd0, exp_done});
    check({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rx_ready"}, {63'd0, bus.rx_ready},    64'd0);
    check({nm, "_we"},       {63'd0, bus.mem_we},      64'd0);
    check({nm, "_addr"},     bus.mem_addr,             64'd0);
    check({nm, "_wdata"},    bus.mem_wdata,            64'd0);
    check({nm, "_resetn"},   {63'd0, bus.core_resetn}, 64'd0);
    check({nm, "_done"},     {63'd0, bus.boot_done},   64'd0);
    check({nm, "_error"},    {63'd0, bus.boot_error},  64'd0);
  endtask

  vec_t        tbl[6];
  logic [63:0] one_w[3];

  initial begin
    tbl[0] = '{"three_word",  16'd3,    3, '{W0, W1, W2}, 1'b0, NO_STALL,             1'b1};
    tbl[1] = '{"backpress",   16'd3,    3, '{W0, W1, W2}, 1'b0, 64'h0000_0000_8000_0008, 1'b1};
    tbl[2] = '{"garbage",     16'd3,    3, '{W0, W1, W2}, 1'b1, NO_STALL,             1'b1};
    tbl[3] = '{"count_zero",  16'd0,    0, '{W0, W1, W2}, 1'b0, NO_STALL,             1'b0};
    tbl[4] = '{"count_4097",  16'd4097, 0, '{W0, W1, W2}, 1'b0, NO_STALL,             1'b0};
    tbl[5] = '{"single_word", 16'd1,    1, '{W2, W0, W1}, 1'b0, NO_STALL,             1'b1};

    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rx_ready_after_reset", {63'd0, bus.rx_ready}, 64'd1);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      stall_addr = tbl[t].stall_at;
      send_frame(tbl[t].count, tbl[t].nwords, tbl[t].w, tbl[t].garbage, 1'b0);
      wait_end(tbl[t].name, tbl[t].exp_done);
      if (tbl[t].stall_at != NO_STALL)
        check({tbl[t].name, "_stall_seen"}, 64'(stall_cnt), 64'd5);
      if (tbl[t].exp_done)
        check({tbl[t].name, "_rx_closed"}, {63'd0, bus.rx_ready}, 64'd0);
      stall_addr = NO_STALL;
    end

    // Recovery: a rejected frame followed by a good one
    do_reset();
    send_frame(16'd0, 0, tbl[0].w, 1'b0, 1'b0);
    wait_end("recover_bad", 1'b0);
    send_byte(8'h11);
    bus.rx_valid = 1'b0;
    send_frame(16'd2, 2, '{W1, W2, W0}, 1'b0, 1'b0);
    wait_end("recover_good", 1'b1);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    send_frame(16'd1, 1, '{W0, W1, W2}, 1'b0, 1'b1);
    wait_end("bad_csum", 1'b0);
    send_frame(16'd1, 1, '{W1, W0, W2}, 1'b0, 1'b0);
    wait_end("after_bad_csum", 1'b1);
`endif

    // Reset in the middle of a word, then a clean single-word frame
    do_reset();
    send_byte(BOOT_MAGIC);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) begin
      one_w[0] = W0;
      send_byte(one_w[0][8*k +: 8]);
    end
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    send_frame(16'd1, 1, '{W1, W0, W2}, 1'b0, 1'b0);
    wait_end("post_reset", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_boot_loader
`default_nettype wire
